regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_rd_port.sv | 43 ++++
 rtl/regfile_mp.sv | 117 +++++++++++
 tb/tb_regfile_mp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and sequencer states for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  // The address must stay at least one bit wide, even for the smallest legal file.
  function automatic int calc_aw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: same-cycle write forwarding (highest write port wins) and the pending flag.
module regfile_rd_port #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic                ready,
  input  logic                en,
  input  logic [AW-1:0]       addr,
  input  logic [XLEN-1:0]     stored,
  input  logic                busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic [XLEN-1:0]     data,
  output logic                pending
);

  logic            hit;
  logic [XLEN-1:0] fwd;

  // Later ports overwrite earlier matches, so the highest-index writer is forwarded.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i] && (wr_addr[i*AW +: AW] == addr)) begin
        hit = 1'b1;
        fwd = wr_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    data    = '0;
    pending = 1'b0;
    if (ready && en && (addr != '0)) begin
      data    = hit ? fwd : stored;
      pending = busy && !hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a self-clearing sequencer and an optional busy scoreboard,
// built only when REGFILE_SCOREBOARD_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = calc_aw(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr
);

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t          state;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            clr_idx <= clr_idx + AW'(1);
          end
        end
        RUN: ready <= 1'b1;
        default: state <= CLEAR;
      endcase
    end
  end

  // Register 0 is never written; reads of it are forced to zero in the read ports.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_idx] <= '0;
      end else begin
        for (int i = 0; i < NWR; i++) begin
          if (wr_en[i] && (wr_addr[i*AW +: AW] != '0))
            regs[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
        end
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREG-1:0] busy;

  // The set is applied after the write clears, so a same-cycle set on the same register wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && (wr_addr[i*AW +: AW] != '0))
          busy[wr_addr[i*AW +: AW]] <= 1'b0;
      end
      if (sb_set_en && (sb_set_addr != '0))
        busy[sb_set_addr] <= 1'b1;
    end
  end
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set_en, sb_set_addr};
`endif

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0] addr;
    logic          busy_bit;

    assign addr = rd_addr[j*AW +: AW];
`ifdef REGFILE_SCOREBOARD_EN
    assign busy_bit = busy[addr];
`else
    assign busy_bit = 1'b0;
`endif

    regfile_rd_port #(
      .XLEN(XLEN),
      .AW  (AW),
      .NWR (NWR)
    ) u_port (
      .ready  (ready),
      .en     (rd_en[j]),
      .addr   (addr),
      .stored (regs[addr]),
      .busy   (busy_bit),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .data   (rd_data[j*XLEN +: XLEN]),
      .pending(rd_busy[j])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Table-driven, scoreboard-checked bench for regfile_mp at default parameters;
// busy expectations follow whether REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;

`ifdef REGFILE_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .sb_set_en  (sb_set_en),
    .sb_set_addr(sb_set_addr)
  );

  typedef struct {
    string       name;
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  ren;
    logic [4:0]  ra0, ra1;
    logic        sb;
    logic [4:0]  sba;
    logic [31:0] e0, e1;
    logic        b0, b1;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] d0, d1;
    logic        b0, b1;
  } exp_t;

  exp_t q[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input string name, input int wen, input int wa0, input logic [31:0] wd0,
                              input int wa1, input logic [31:0] wd1, input int ren, input int ra0,
                              input int ra1, input int sb, input int sba, input logic [31:0] e0,
                              input logic [31:0] e1, input int b0, input int b1);
    vec_t v;
    v.name = name;  v.wen = 2'(wen);
    v.wa0 = 5'(wa0); v.wd0 = wd0; v.wa1 = 5'(wa1); v.wd1 = wd1;
    v.ren = 2'(ren); v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
    v.sb = 1'(sb);   v.sba = 5'(sba);
    v.e0 = e0; v.e1 = e1; v.b0 = 1'(b0); v.b1 = 1'(b1);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wr_en       = v.wen;
    wr_addr     = {v.wa1, v.wa0};
    wr_data     = {v.wd1, v.wd0};
    rd_en       = v.ren;
    rd_addr     = {v.ra1, v.ra0};
    sb_set_en   = v.sb;
    sb_set_addr = v.sba;
    q.push_back('{v.name, v.e0, v.e1, v.b0 & SB, v.b1 & SB});
  endtask

  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    if (q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      check({e.name, " rd_data0"}, rd_data[31:0], e.d0);
      check({e.name, " rd_data1"}, rd_data[63:32], e.d1);
      check({e.name, " rd_busy0"}, {31'b0, rd_busy[0]}, {31'b0, e.b0});
      check({e.name, " rd_busy1"}, {31'b0, rd_busy[1]}, {31'b0, e.b1});
    end
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0;
    sb_set_en = 1'b0; sb_set_addr = '0;
  endtask

  // Counts posedges from rst release until ready rises; a clear must take 31.
  task automatic wait_ready(input string nm);
    int cnt = 0;
    while (!ready && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check(nm, 32'(cnt), 32'd31);
  endtask

  initial begin
    vecs.push_back(mk("same_addr_wr",   3, 5, 'h11, 5, 'h22, 3, 5, 5, 0, 0, 'h22, 'h22, 0, 0));
    vecs.push_back(mk("x5_next",        0, 0, 0, 0, 0, 3, 5, 0, 0, 0, 'h22, 0, 0, 0));
    vecs.push_back(mk("fwd_x7",         1, 7, 'hDEADBEEF, 0, 0, 1, 7, 7, 0, 0, 'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk("wr_x0",          3, 3, 'h33, 0, 'hFFFFFFFF, 3, 0, 3, 0, 0, 0, 'h33, 0, 0));
    vecs.push_back(mk("x0_x7_stored",   0, 0, 0, 0, 0, 3, 0, 7, 0, 0, 0, 'hDEADBEEF, 0, 0));
    vecs.push_back(mk("sb_set_x9",      0, 0, 0, 0, 0, 1, 9, 0, 1, 9, 0, 0, 0, 0));
    vecs.push_back(mk("x9_busy",        0, 0, 0, 0, 0, 3, 9, 9, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("wr_x9_clears",   1, 9, 3, 0, 0, 1, 9, 9, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk("x9_after_wr",    0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk("set_and_wr_x9",  2, 0, 0, 9, 4, 1, 9, 0, 1, 9, 4, 0, 0, 0));
    vecs.push_back(mk("set_wins_x9",    0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 4, 0, 1, 0));
    vecs.push_back(mk("sb_set_x4",      0, 0, 0, 0, 0, 1, 4, 0, 1, 4, 0, 0, 0, 0));
    vecs.push_back(mk("x4_busy",        0, 0, 0, 0, 0, 3, 4, 9, 0, 0, 0, 4, 1, 1));
    vecs.push_back(mk("wr_x4_x6_rdoff", 3, 4, 'h44, 6, 'h66, 0, 4, 6, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("x4_x6_stored",   0, 0, 0, 0, 0, 3, 4, 6, 0, 0, 'h44, 'h66, 0, 0));
    vecs.push_back(mk("sb_set_x0",      0, 0, 0, 0, 0, 3, 0, 9, 1, 0, 0, 4, 0, 1));
    vecs.push_back(mk("x0_never_busy",  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("two_addr_wr",    3, 10, 1, 11, 2, 3, 10, 11, 0, 0, 1, 2, 0, 0));
    vecs.push_back(mk("x10_x11_stored", 0, 0, 0, 0, 0, 3, 11, 10, 0, 0, 2, 1, 0, 0));

    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_ready", {31'b0, ready}, 32'd0);
    applyStimulus(mk("in_reset", 0, 0, 0, 0, 0, 3, 5, 9, 1, 5, 0, 0, 0, 0));
    checkOutput();
    idle();
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready("clear_cycles");

    for (int i = 0; i < 32; i++)
      step(mk("cleared", 0, 0, 0, 0, 0, 3, i, 31 - i, 0, 0, 0, 0, 0, 0));

    foreach (vecs[k]) step(vecs[k]);
    idle();

    // Restart the clear at index 10 while a write is held, then confirm a full wipe.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    step(mk("mid_clear_read", 0, 0, 0, 0, 0, 3, 7, 4, 0, 0, 0, 0, 0, 0));
    check("mid_clear_ready", {31'b0, ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wr_en = 2'b11; wr_addr = {5'd30, 5'd5}; wr_data = {32'h5A5A5A5A, 32'h55};
    sb_set_en = 1'b1; sb_set_addr = 5'd12;
    wait_ready("restart_cycles");
    idle();
    step(mk("after_clear_a", 0, 0, 0, 0, 0, 3, 5, 30, 0, 0, 0, 0, 0, 0));
    step(mk("after_clear_b", 0, 0, 0, 0, 0, 3, 7, 9, 0, 0, 0, 0, 0, 0));
    step(mk("after_clear_c", 0, 0, 0, 0, 0, 3, 12, 4, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
